// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution unit with IT blocks.
// Holds the condition-code enum, the flag bit positions inside {N,Z,C,V},
// and the IT-block FSM state type.
package cond_pkg;

   // ARM-style condition field encodings.
   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_e;

   // Bit positions of each flag inside the 4-bit flag word.
   localparam int N = 3;
   localparam int Z = 2;
   localparam int C = 1;
   localparam int V = 0;

   // IT-block tracker states.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: decides whether a 4-bit condition
// holds for the given {N,Z,C,V} flags. AL and NV always pass.
module cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   // Standard N/Z/C/V decode of the condition field.
   always_comb begin
      // NOTE: pass gets a default before the case so no path leaves it unassigned (no latch).
      pass = 1'b1;
      case (cond_e'(cond))
         EQ:      pass =  flags[Z];
         NE:      pass = ~flags[Z];
         CS:      pass =  flags[C];
         CC:      pass = ~flags[C];
         MI:      pass =  flags[N];
         PL:      pass = ~flags[N];
         VS:      pass =  flags[V];
         VC:      pass = ~flags[V];
         HI:      pass =  flags[C] & ~flags[Z];
         LS:      pass = ~flags[C] |  flags[Z];
         GE:      pass = (flags[N] == flags[V]);
         LT:      pass = (flags[N] != flags[V]);
         GT:      pass = ~flags[Z] & (flags[N] == flags[V]);
         LE:      pass =  flags[Z] | (flags[N] != flags[V]);
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit_it.sv
// Conditional-execution unit with IT-block tracking and an optional flag stack.
// Gates the decoder's PCS/RegW/MemW/Branch requests by the effective condition,
// owns the architectural flag register, and follows IT blocks of up to MAX_IT
// slots. Define COND_UNIT_FLAG_STACK_EN to build the STK_DEPTH-entry flag
// stack driven by FlagSave/FlagRestore; without it those inputs are ignored.
module cond_unit_it
   import cond_pkg::*;
#(
   parameter int MAX_IT    = 4,
   parameter int STK_DEPTH = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              InstrValid,
   input  logic [3:0]        Cond,
   input  logic [3:0]        ALUFlags,
   input  logic [1:0]        FlagW,
   input  logic              PCS,
   input  logic              RegW,
   input  logic              MemW,
   input  logic              Branch,
   input  logic              ITStart,
   input  logic [3:0]        ITCond,
   input  logic [2:0]        ITCount,
   input  logic [MAX_IT-1:0] ITPattern,
   input  logic              FlagSave,
   input  logic              FlagRestore,
   output logic              PCSrc,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              CondEx,
   output logic [3:0]        Flags,
   output logic              InIT,
   output logic [2:0]        ITRemain,
   output logic              ITErr,
   output logic              StkErr,
   output logic              StkFull,
   output logic              StkEmpty
);

   localparam int         SW      = (MAX_IT > 1) ? $clog2(MAX_IT) : 1;
   localparam logic [2:0] MAX_CNT = 3'(MAX_IT);

   it_state_e         state_q;
   logic [3:0]        base_q;
   logic [MAX_IT-1:0] pat_q;
   logic [SW-1:0]     slot_q;
   logic [2:0]        remain_q;

   logic [3:0]        flags_q;
   logic [3:0]        flags_wr;
   logic [3:0]        flags_d;
   logic [3:0]        eff_cond;
   logic              pass;
   logic              count_bad;
   logic              it_err_d;
   logic              it_err_q;

   assign InIT     = (state_q == ACTIVE);
   assign ITRemain = remain_q;
   assign Flags    = flags_q;
   assign ITErr    = it_err_q;

   // Inside a block the slot condition is the base, flipped in bit 0 for an else slot.
   assign eff_cond = InIT ? {base_q[3:1], base_q[0] ^ ~pat_q[slot_q]} : Cond;

   cond_eval u_cond_eval (
      .cond  (eff_cond),
      .flags (flags_q),
      .pass  (pass)
   );

   // An IT instruction itself always executes so that it can open its block.
   assign CondEx   = ITStart | pass;
   assign PCSrc    = (PCS | Branch) & CondEx & InstrValid;
   assign RegWrite = RegW & CondEx & InstrValid;
   assign MemWrite = MemW & CondEx & InstrValid;

   assign count_bad = (ITCount == 3'd0) || (ITCount > MAX_CNT);
   assign it_err_d  = InstrValid & ITStart & (InIT | count_bad);

   // Flag value produced by an ALU write this cycle, before any stack pop.
   always_comb begin
      flags_wr = flags_q;
      if (InstrValid && CondEx && FlagW[1]) flags_wr[N:Z] = ALUFlags[N:Z];
      if (InstrValid && CondEx && FlagW[0]) flags_wr[C:V] = ALUFlags[C:V];
   end

`ifdef COND_UNIT_FLAG_STACK_EN
   localparam int            PW      = $clog2(STK_DEPTH + 1);
   localparam int            AW      = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
   localparam logic [PW-1:0] STK_TOP = PW'(STK_DEPTH);

   logic [3:0]    stk_mem [STK_DEPTH];
   logic [PW-1:0] sp_q;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic          push_req;
   logic          pop_req;
   logic          both_req;
   logic          do_push;
   logic          do_pop;
   logic          stk_err_d;
   logic          stk_err_q;

   assign StkFull  = (sp_q == STK_TOP);
   assign StkEmpty = (sp_q == '0);
   assign StkErr   = stk_err_q;

   // Stack requests depend only on InstrValid; a failed condition still pushes or pops.
   assign push_req  = InstrValid & FlagSave & ~FlagRestore;
   assign pop_req   = InstrValid & FlagRestore & ~FlagSave;
   assign both_req  = InstrValid & FlagSave & FlagRestore;
   assign do_push   = push_req & ~StkFull;
   assign do_pop    = pop_req & ~StkEmpty;
   assign stk_err_d = both_req | (push_req & StkFull) | (pop_req & StkEmpty);

   assign wr_idx  = AW'(sp_q);
   assign rd_idx  = AW'(sp_q - PW'(1));
   assign flags_d = do_pop ? stk_mem[rd_idx] : flags_wr;

   // Stack storage captures the flags as they were before this edge's write.
   always_ff @(posedge clk) begin
      // NOTE: the entries are not reset; the pointer alone decides what is valid.
      if (do_push) stk_mem[wr_idx] <= flags_q;
   end

   // Stack pointer and stack error pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp_q      <= '0;
         stk_err_q <= 1'b0;
      end else begin
         stk_err_q <= stk_err_d;
         if (do_push)     sp_q <= sp_q + PW'(1);
         else if (do_pop) sp_q <= sp_q - PW'(1);
      end
   end
`else
   logic unused_stk;
   localparam int unused_stk_depth = STK_DEPTH;

   assign unused_stk = FlagSave ^ FlagRestore;
   assign flags_d    = flags_wr;
   assign StkFull    = 1'b0;
   assign StkEmpty   = 1'b1;
   assign StkErr     = 1'b0;
`endif

   // Architectural flag register and the IT error pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state always uses non-blocking assignment.
         flags_q  <= 4'b0000;
         it_err_q <= 1'b0;
      end else begin
         flags_q  <= flags_d;
         it_err_q <= it_err_d;
      end
   end

   // IT-block tracker: opens on a legal IT, counts slots down, closes early on a taken branch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         base_q   <= 4'h0;
         pat_q    <= '0;
         slot_q   <= '0;
         remain_q <= 3'd0;
      end else if (InstrValid) begin
         case (state_q)
            IDLE: begin
               if (ITStart && !count_bad) begin
                  state_q  <= ACTIVE;
                  base_q   <= ITCond;
                  pat_q    <= ITPattern;
                  slot_q   <= '0;
                  remain_q <= ITCount;
               end
            end
            ACTIVE: begin
               if (PCSrc || (remain_q == 3'd1)) begin
                  state_q  <= IDLE;
                  slot_q   <= '0;
                  remain_q <= 3'd0;
               end else begin
                  slot_q   <= slot_q + SW'(1);
                  remain_q <= remain_q - 3'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cond_unit_it.sv
// Self-checking bench for cond_unit_it. A behavioural model (IT block as a queue
// of slot conditions, flag stack as a queue) is compared against every output on
// each falling edge; directed steps add hand-computed literal expectations.
// Works with or without COND_UNIT_FLAG_STACK_EN defined.
module tb_cond_unit_it;

   localparam int MAX_IT    = 4;
   localparam int STK_DEPTH = 2;
`ifdef COND_UNIT_FLAG_STACK_EN
   localparam bit STK_EN = 1'b1;
`else
   localparam bit STK_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        InstrValid;
   logic [3:0]  Cond;
   logic [3:0]  ALUFlags;
   logic [1:0]  FlagW;
   logic        PCS;
   logic        RegW;
   logic        MemW;
   logic        Branch;
   logic        ITStart;
   logic [3:0]  ITCond;
   logic [2:0]  ITCount;
   logic [3:0]  ITPattern;
   logic        FlagSave;
   logic        FlagRestore;
   logic        PCSrc;
   logic        RegWrite;
   logic        MemWrite;
   logic        CondEx;
   logic [3:0]  Flags;
   logic        InIT;
   logic [2:0]  ITRemain;
   logic        ITErr;
   logic        StkErr;
   logic        StkFull;
   logic        StkEmpty;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // Model state.
   logic [3:0] m_flags;
   logic [3:0] m_slots [$];
   logic [3:0] m_stack [$];
   bit         m_iterr;
   bit         m_stkerr;

   cond_unit_it #(
      .MAX_IT    (MAX_IT),
      .STK_DEPTH (STK_DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .InstrValid  (InstrValid),
      .Cond        (Cond),
      .ALUFlags    (ALUFlags),
      .FlagW       (FlagW),
      .PCS         (PCS),
      .RegW        (RegW),
      .MemW        (MemW),
      .Branch      (Branch),
      .ITStart     (ITStart),
      .ITCond      (ITCond),
      .ITCount     (ITCount),
      .ITPattern   (ITPattern),
      .FlagSave    (FlagSave),
      .FlagRestore (FlagRestore),
      .PCSrc       (PCSrc),
      .RegWrite    (RegWrite),
      .MemWrite    (MemWrite),
      .CondEx      (CondEx),
      .Flags       (Flags),
      .InIT        (InIT),
      .ITRemain    (ITRemain),
      .ITErr       (ITErr),
      .StkErr      (StkErr),
      .StkFull     (StkFull),
      .StkEmpty    (StkEmpty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Condition truth from the pair rule: even code tests a predicate, odd code its inverse.
   function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
      bit n  = f[3];
      bit z  = f[2];
      bit cf = f[1];
      bit v  = f[0];
      bit r;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cf;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cf && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: return 1'b1;
      endcase
      return r ^ c[0];
   endfunction

   function automatic bit m_condex();
      logic [3:0] eff;
      eff = (m_slots.size() > 0) ? m_slots[0] : Cond;
      return ITStart || cond_true(eff, m_flags);
   endfunction

   task automatic model_reset();
      m_flags  = 4'b0000;
      m_slots.delete();
      m_stack.delete();
      m_iterr  = 1'b0;
      m_stkerr = 1'b0;
   endtask

   // Advance the model across one rising edge using the inputs present at that edge.
   task automatic model_step();
      bit         ce;
      bit         taken;
      logic [3:0] nf;
      if (!reset) return;
      m_iterr  = 1'b0;
      m_stkerr = 1'b0;
      if (!InstrValid) return;
      ce    = m_condex();
      taken = (PCS || Branch) && ce;
      nf    = m_flags;
      if (ce && FlagW[1]) nf[3:2] = ALUFlags[3:2];
      if (ce && FlagW[0]) nf[1:0] = ALUFlags[1:0];
      if (STK_EN) begin
         if (FlagSave && FlagRestore) m_stkerr = 1'b1;
         else if (FlagSave) begin
            if (m_stack.size() == STK_DEPTH) m_stkerr = 1'b1;
            else m_stack.push_back(m_flags);
         end else if (FlagRestore) begin
            if (m_stack.size() == 0) m_stkerr = 1'b1;
            else nf = m_stack.pop_back();
         end
      end
      m_flags = nf;
      if (m_slots.size() > 0) begin
         if (ITStart) m_iterr = 1'b1;
         if (taken) m_slots.delete();
         else void'(m_slots.pop_front());
      end else if (ITStart) begin
         if (ITCount == 0 || ITCount > MAX_IT) m_iterr = 1'b1;
         else for (int i = 0; i < ITCount; i++)
            m_slots.push_back(ITPattern[i] ? ITCond : {ITCond[3:1], ~ITCond[0]});
      end
   endtask

   // Continuous comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            bit ce;
            ce = m_condex();
            check("cyc_condex",   CondEx,   ce);
            check("cyc_pcsrc",    PCSrc,    (PCS || Branch) && ce && InstrValid);
            check("cyc_regwrite", RegWrite, RegW && ce && InstrValid);
            check("cyc_memwrite", MemWrite, MemW && ce && InstrValid);
            check("cyc_flags",    Flags,    m_flags);
            check("cyc_init",     InIT,     m_slots.size() > 0);
            check("cyc_itremain", ITRemain, m_slots.size());
            check("cyc_iterr",    ITErr,    m_iterr);
            check("cyc_stkerr",   StkErr,   m_stkerr);
            check("cyc_stkfull",  StkFull,  STK_EN && (m_stack.size() == STK_DEPTH));
            check("cyc_stkempty", StkEmpty, !STK_EN || (m_stack.size() == 0));
         end
      end
   end

   task automatic idle_inputs();
      InstrValid  = 1'b1;
      Cond        = 4'hE;
      ALUFlags    = 4'h0;
      FlagW       = 2'b00;
      PCS         = 1'b0;
      RegW        = 1'b0;
      MemW        = 1'b0;
      Branch      = 1'b0;
      ITStart     = 1'b0;
      ITCond      = 4'h0;
      ITCount     = 3'd0;
      ITPattern   = 4'h0;
      FlagSave    = 1'b0;
      FlagRestore = 1'b0;
   endtask

   // Apply the current inputs at the next rising edge, then return to defaults.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      idle_inputs();
   endtask

   task automatic set_flags(input logic [3:0] v);
      ALUFlags = v;
      FlagW    = 2'b11;
      tick();
   endtask

   task automatic it_open(input logic [3:0] c, input logic [2:0] cnt, input logic [3:0] pat);
      ITStart   = 1'b1;
      ITCond    = c;
      ITCount   = cnt;
      ITPattern = pat;
      tick();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      model_reset();
      chk_on = 1'b1;
      #12 reset = 1'b1;
      @(posedge clk);
      #1;

      // Reset state.
      check("rst_flags",    Flags,    4'b0000);
      check("rst_init",     InIT,     1'b0);
      check("rst_itremain", ITRemain, 3'd0);
      check("rst_iterr",    ITErr,    1'b0);
      check("rst_stkempty", StkEmpty, 1'b1);
      check("rst_stkfull",  StkFull,  1'b0);

      // EQ fails with Z=0, then an ADDS sets Z and EQ passes.
      Cond = 4'h0; RegW = 1'b1; #1;
      check("eq_z0_regwrite", RegWrite, 1'b0);
      tick();
      RegW = 1'b1; set_flags(4'b0100);
      check("adds_flags", Flags, 4'b0100);
      Cond = 4'h0; RegW = 1'b1; #1;
      check("eq_z1_regwrite", RegWrite, 1'b1);
      tick();

      // Partial flag writes and a write blocked by a failing condition.
      ALUFlags = 4'b1011; FlagW = 2'b10; tick();
      check("flagw_nz", Flags, 4'b1000);
      ALUFlags = 4'b0111; FlagW = 2'b01; tick();
      check("flagw_cv", Flags, 4'b1011);
      Cond = 4'h0; ALUFlags = 4'b0100; FlagW = 2'b11; tick();
      check("flagw_blocked", Flags, 4'b1011);
      set_flags(4'b0100);

      // Three-slot block EQ with pattern then/else/then.
      it_open(4'h0, 3'd3, 4'b0101);
      RegW = 1'b1; #1;
      check("it3_s0_regwrite", RegWrite, 1'b1);
      check("it3_s0_remain",   ITRemain, 3'd3);
      tick();
      RegW = 1'b1; #1;
      check("it3_s1_regwrite", RegWrite, 1'b0);
      check("it3_s1_remain",   ITRemain, 3'd2);
      tick();
      RegW = 1'b1; #1;
      check("it3_s2_regwrite", RegWrite, 1'b1);
      check("it3_s2_remain",   ITRemain, 3'd1);
      tick();
      Cond = 4'h1; RegW = 1'b1; #1;
      check("it3_after_init",     InIT,     1'b0);
      check("it3_after_regwrite", RegWrite, 1'b0);
      tick();

      // Taken branch in slot 1 closes a four-slot block.
      it_open(4'hE, 3'd4, 4'b1111);
      RegW = 1'b1; tick();
      Branch = 1'b1; #1;
      check("br_pcsrc", PCSrc, 1'b1);
      tick();
      check("br_after_init", InIT, 1'b0);

      // Nested IT start consumes its slot and flags an error; stalls hold the block.
      it_open(4'h0, 3'd4, 4'b1111);
      RegW = 1'b1; tick();
      it_open(4'h1, 3'd2, 4'b0011);
      check("nest_iterr",  ITErr,    1'b1);
      check("nest_remain", ITRemain, 3'd2);
      for (int i = 0; i < 3; i++) begin
         InstrValid = 1'b0; RegW = 1'b1; tick();
         check("stall_remain", ITRemain, 3'd2);
      end
      check("stall_iterr", ITErr, 1'b0);
      RegW = 1'b1; tick();
      check("tail_remain", ITRemain, 3'd1);
      RegW = 1'b1; tick();
      check("tail_init", InIT, 1'b0);

      // Illegal slot counts.
      it_open(4'h0, 3'd0, 4'b1111);
      check("cnt0_iterr", ITErr, 1'b1);
      check("cnt0_init",  InIT,  1'b0);
      it_open(4'h0, 3'd5, 4'b1111);
      check("cnt5_iterr", ITErr, 1'b1);
      check("cnt5_init",  InIT,  1'b0);

      // Condition sweep across several flag settings; the model checks every cycle.
      for (int k = 0; k < 8; k++) begin
         set_flags(4'(k * 3 + 1));
         for (int c = 0; c < 16; c++) begin
            Cond   = 4'(c);
            RegW   = 1'b1;
            MemW   = c[0];
            Branch = c[1];
            PCS    = c[2];
            tick();
         end
      end

      // Flag stack.
      set_flags(4'b1010);
      FlagSave = 1'b1; tick();
      check("stk_push1_empty", StkEmpty, STK_EN ? 1'b0 : 1'b1);
      set_flags(4'b0101);
      FlagSave = 1'b1; tick();
      check("stk_push2_full", StkFull, STK_EN);
      FlagSave = 1'b1; tick();
      check("stk_over_err",  StkErr,  STK_EN);
      check("stk_over_full", StkFull, STK_EN);
      FlagRestore = 1'b1; tick();
      check("stk_pop1_flags", Flags, 4'b0101);
      FlagRestore = 1'b1; tick();
      check("stk_pop2_flags", Flags, STK_EN ? 4'b1010 : 4'b0101);
      FlagRestore = 1'b1; tick();
      check("stk_under_err",   StkErr,   STK_EN);
      check("stk_under_empty", StkEmpty, 1'b1);
      FlagSave = 1'b1; tick();
      FlagRestore = 1'b1; ALUFlags = 4'b1111; FlagW = 2'b11; tick();
      check("stk_pop_wins", Flags, STK_EN ? 4'b1010 : 4'b1111);
      FlagSave = 1'b1; ALUFlags = 4'b0011; FlagW = 2'b11; tick();
      check("stk_save_write_flags", Flags, 4'b0011);
      FlagRestore = 1'b1; tick();
      check("stk_prewrite_pushed", Flags, STK_EN ? 4'b1010 : 4'b0011);
      FlagSave = 1'b1; FlagRestore = 1'b1; ALUFlags = 4'b0110; FlagW = 2'b11; tick();
      check("stk_both_err",   StkErr,   STK_EN);
      check("stk_both_flags", Flags,    4'b0110);
      check("stk_both_empty", StkEmpty, 1'b1);
      Cond = 4'h1; FlagSave = 1'b1; tick();
      check("stk_save_condfail", StkEmpty, STK_EN ? 1'b0 : 1'b1);

      // Asynchronous reset in the middle of a block.
      it_open(4'h0, 3'd4, 4'b1111);
      RegW = 1'b1; tick();
      #2 reset = 1'b0;
      model_reset();
      #1;
      check("arst_init",     InIT,     1'b0);
      check("arst_flags",    Flags,    4'b0000);
      check("arst_itremain", ITRemain, 3'd0);
      check("arst_stkempty", StkEmpty, 1'b1);
      @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      Cond = 4'h0; RegW = 1'b1; #1;
      check("post_rst_regwrite", RegWrite, 1'b0);
      tick();
      tick();

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/cond_unit_it.md
COND_UNIT_IT -- requirements
Module: cond_unit_it

Interface
REQ-001 Parameter MAX_IT, default 4, is the maximum IT-block length in slots (legal 1..4).
REQ-002 Parameter STK_DEPTH, default 4, is the number of flag-stack entries (legal 1..8).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 InstrValid  in  1  an instruction retires this cycle; all state advances only when high.
REQ-006 Cond  in  4  instruction condition field.
REQ-007 ALUFlags  in  4  {N,Z,C,V} from the ALU.
REQ-008 FlagW  in  2  [1] writes N,Z; [0] writes C,V.
REQ-009 PCS, RegW, MemW, Branch  in  1 each  unconditioned decoder requests.
REQ-010 ITStart  in  1  current instruction is an IT instruction.
REQ-011 ITCond  in  4  IT base condition.
REQ-012 ITCount  in  3  number of slots, 1..MAX_IT.
REQ-013 ITPattern  in  MAX_IT  per slot: 1 = then, 0 = else; bit 0 is slot 0.
REQ-014 FlagSave, FlagRestore  in  1 each  push/pop of the flag register.
REQ-015 PCSrc, RegWrite, MemWrite, CondEx  out  1 each  gated controls and the condition result.
REQ-016 Flags  out  4  architectural flag register.
REQ-017 InIT  out  1  an IT block is active.
REQ-018 ITRemain  out  3  slots left in the active block.
REQ-019 ITErr, StkErr  out  1 each  single-cycle error pulses.
REQ-020 StkFull, StkEmpty  out  1 each  flag-stack status.

Function
REQ-021 Effective condition: when InIT=0, it is Cond. When InIT=1, it is the stored base condition with bit 0 inverted if the current slot's pattern bit is 0.
REQ-022 Effective conditions 1110 and 1111 evaluate true unconditionally; all others use the standard N/Z/C/V decode.
REQ-023 CondEx is combinational and is forced 1 while ITStart=1.
REQ-024 PCSrc = (PCS|Branch)&CondEx&InstrValid.
REQ-025 RegWrite = RegW&CondEx&InstrValid.
REQ-026 MemWrite = MemW&CondEx&InstrValid.
REQ-027 Flags[3:2] load ALUFlags[3:2] on an edge with InstrValid&CondEx&FlagW[1]; Flags[1:0] load likewise with FlagW[0].
REQ-028 IT FSM has two states, IDLE and ACTIVE. IDLE->ACTIVE on InstrValid&ITStart with ITCount in 1..MAX_IT: latch condition and pattern, set ITRemain=ITCount, slot=0.
REQ-029 In ACTIVE, each InstrValid decrements ITRemain and advances the slot; the FSM returns to IDLE when ITRemain reaches 0, so InIT=0 for the next instruction.
REQ-030 A slot whose condition fails still consumes that slot.
REQ-031 A taken PCSrc in ACTIVE forces IDLE at the next edge, regardless of ITRemain.
REQ-032 ITStart while ACTIVE is ignored as an IT (treated as an ordinary instruction, consuming its slot) and pulses ITErr.
REQ-033 ITStart with ITCount=0 or ITCount>MAX_IT leaves the FSM in IDLE and pulses ITErr.
REQ-034 Stall (InstrValid=0) freezes all state.
REQ-035 FlagSave pushes Flags; on the same edge a flag write still updates Flags, and the pre-write value is pushed.
REQ-036 FlagRestore pops into Flags, overriding any same-cycle flag write.
REQ-037 Push when full or pop when empty: no state change, StkErr pulses.
REQ-038 FlagSave and FlagRestore together: stack unchanged, StkErr pulses, normal flag write proceeds.
REQ-039 Stack operations require InstrValid and are not gated by CondEx.

Reset
REQ-040 reset low asynchronously clears Flags=0000, IT FSM=IDLE, ITRemain=0, the stack pointer to 0 (StkEmpty=1, StkFull=0), and ITErr=StkErr=0.
REQ-041 Reset during an active IT block abandons the block; the outputs are the combinational functions of the inputs with the reset state.

Configuration
REQ-042 With macro COND_UNIT_FLAG_STACK_EN defined, the flag stack of REQ-035..039 is built.
REQ-043 Without COND_UNIT_FLAG_STACK_EN, no stack storage exists: FlagSave/FlagRestore are ignored, StkEmpty=1, StkFull=0, StkErr=0.

Structure
REQ-044 Package cond_pkg holds the condition-code enum (EQ..AL, NV), flag index constants N=3, Z=2, C=1, V=0, and the IT FSM state typedef.
REQ-045 Sub-module cond_eval (combinational: 4-bit condition plus flags -> pass) is instantiated once.

Verification
REQ-046 After reset, drive Cond=0000 with Flags=0000 and RegW=1 -> RegWrite=0; drive ADDS with ALUFlags=0100, FlagW=11 -> next Flags=0100, and Cond=0000 now gives RegWrite=1.
REQ-047 With Z=1, issue ITStart, ITCond=0000, ITCount=3, ITPattern=101, then 3 RegW instructions -> RegWrite pattern 1,0,1; ITRemain 3,2,1; InIT=0 on the 4th instruction.
REQ-048 Within a 4-slot block, a taken Branch in slot 1 -> InIT=0 at the next instruction; ITErr on nested ITStart; InstrValid=0 for 3 cycles mid-block -> ITRemain holds.
REQ-049 With the macro defined and STK_DEPTH=2: Flags=1010 save, Flags=0101 save, third save -> StkErr and StkFull=1; restore twice -> Flags 0101 then 1010; third restore -> StkErr.
REQ-050 Restore together with FlagW=11 -> popped value wins; reset asserted mid-block -> InIT=0 and Flags=0000 immediately, without waiting for a clock edge.
